// File: rtl/div.sv
// Multicycle restoring divider (DIV/DIVU): result valid 34 edges after start, or 2 edges for divide-by-zero.
// No backpressure: the requester holds start_i until ready_o and drops it to release the result.
module div #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [2*DATA_W-1:0] result_d;
  logic                ready_d;

  logic                op1_neg, op2_neg;
  logic [DATA_W-1:0]   op1_mag, op2_mag;
  logic [DATA_W:0]     trial, diff;

  assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign op1_mag = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_mag = op2_neg ? -opdata2_i : opdata2_i;

  // Dividend bits shift out of quo_q's MSB into the partial remainder while quotient bits enter at the LSB.
  assign trial = {rem_q, quo_q[DATA_W-1]};
  assign diff  = trial - {1'b0, dvs_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_o;
    ready_d  = ready_o;
    case (state_q)
      FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = BYZERO;
          end else begin
            state_d = ON;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = op1_mag;
            dvs_d   = op2_mag;
            qneg_d  = op1_neg ^ op2_neg;
            rneg_d  = op1_neg;
          end
        end
      end
      BYZERO: begin
        state_d  = END;
        result_d = '0;
        ready_d  = 1'b1;
      end
      ON: begin
        if (annul_i) begin
          state_d  = FREE;
          cnt_d    = '0;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q == CNT_W'(DATA_W)) begin
          state_d  = END;
          ready_d  = 1'b1;
          result_d = {(rneg_q ? -rem_q : rem_q), (qneg_q ? -quo_q : quo_q)};
        end else begin
          quo_d = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
          rem_d = diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
          cnt_d = cnt_q + 1'b1;
        end
      end
      END: begin
        if (!start_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_o <= result_d;
      ready_o  <= ready_d;
    end
  end

endmodule

// File: tb/tb_div.sv
// Bench for div: directed handshake scenarios plus random operands against an arithmetic reference.
module tb_div;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int passed = 0;
  int total  = 0;

  div #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Truncating division on 64-bit integers: quotient rounds toward zero, remainder takes the dividend's sign.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Counts edges until ready_o, including the start-sampling edge; bounded.
  task automatic wait_ready(input bit scramble, output int n);
    n = 0;
    do begin
      step();
      n++;
      if (scramble) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom);
      end
    end while (!ready_o && n < 40);
  endtask

  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp;
    int n;
    exp          = ref_div(sgn, a, b);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    wait_ready(1'b1, n);
    chk({tag, " latency"}, 64'(n), (b == 32'd0) ? 64'd2 : 64'd34);
    chk({tag, " result"}, result_o, exp);
    annul_i = 1'b1;
    step();
    chk({tag, " end-hold ready"}, 64'(ready_o), 64'd1);
    chk({tag, " end-hold result"}, result_o, exp);
    annul_i = 1'b0;
    start_i = 1'b0;
    step();
    chk({tag, " release ready"}, 64'(ready_o), 64'd0);
    chk({tag, " release result"}, result_o, 64'd0);
  endtask

  initial begin
    int n;
    bit saw_ready;
    logic [31:0] a, b;

    repeat (2) step();
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    rst = 1'b1;
    step();

    run_div(1'b0, 32'd100, 32'd7, "divu 100/7");
    chk("divu 100/7 literal", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, "div -7/2");
    run_div(1'b1, 32'h00000007, 32'hFFFFFFFE, "div 7/-2");
    run_div(1'b1, 32'h12345678, 32'h0, "div by zero");
    run_div(1'b0, 32'h12345678, 32'h0, "divu by zero");
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, "div overflow");
    run_div(1'b0, 32'h80000000, 32'hFFFFFFFF, "divu big");

    // Annul on edge 10 of a run.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    saw_ready    = 1'b0;
    repeat (9) begin
      step();
      if (ready_o) saw_ready = 1'b1;
    end
    start_i = 1'b0;
    annul_i = 1'b1;
    step();
    if (ready_o) saw_ready = 1'b1;
    annul_i = 1'b0;
    repeat (3) begin
      step();
      if (ready_o) saw_ready = 1'b1;
    end
    chk("annul no ready", 64'(saw_ready), 64'd0);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, "after annul");

    // Start together with annul in FREE is ignored.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    annul_i      = 1'b1;
    repeat (5) step();
    chk("start+annul ready", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    wait_ready(1'b0, n);
    chk("start+annul then latency", 64'(n), 64'd34);
    chk("start+annul then result", result_o, ref_div(1'b0, 32'd1000, 32'd3));
    start_i = 1'b0;
    step();

    // Reset on edge 20 of a run with start held through the release.
    signed_div_i = 1'b1;
    opdata1_i    = 32'hFFFFFC18;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (19) step();
    rst = 1'b0;
    step();
    chk("mid reset ready", 64'(ready_o), 64'd0);
    chk("mid reset result", result_o, 64'd0);
    rst = 1'b1;
    wait_ready(1'b0, n);
    chk("post reset latency", 64'(n), 64'd34);
    chk("post reset result", result_o, ref_div(1'b1, 32'hFFFFFC18, 32'd3));
    start_i = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(1, 15));
        1:       b = -32'($urandom_range(1, 15));
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_div(1'($urandom), a, b, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multicycle integer divider. It is the responder to the EX stage's DIV/DIVU requests.
- EX raises a request with operands; this block runs a 32-iteration restoring shift-subtract and returns {remainder, quotient} with a ready flag. EX then writes remainder to HI and quotient to LO.
- EX holds its pipeline stall request while this block is busy.
- Sits beside ex, with a cycle-accurate handshake to it.

Parameters:
- DATA_W, 32, operand width. Iteration count equals DATA_W. Result width is 2*DATA_W.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, active-low (0 = reset), synchronous; sampled only on the rising edge of clk
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); latched at start
- opdata1_i  input  DATA_W  dividend; latched at start
- opdata2_i  input  DATA_W  divisor; latched at start
- start_i  input  1  request; held high by EX until ready_o is seen, then dropped
- annul_i  input  1  cancel in-flight division (branch-delay/flush kill)
- result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}; valid only while ready_o = 1
- ready_o  output  1  result valid

Behaviour:
- Reset (rst = 0 at an edge):
  - state = FREE, cnt = 0, ready_o = 0, result_o = 0.
  - Overrides every other input, including mid-operation.
- States: FREE, BYZERO, ON, END. All outputs are registered.
- FREE:
  - start_i = 1 and annul_i = 0, divisor == 0 → BYZERO.
  - start_i = 1 and annul_i = 0, divisor != 0 → ON. Latch operands, cnt = 0.
  - start_i = 1 and annul_i = 1 → stay FREE; the request is ignored.
  - ready_o = 0, result_o = 0.
- Signed preprocessing (signed_div_i = 1), at start:
  - Negative operands are replaced by their two's-complement magnitude.
  - Signs are recorded: qneg = sign1 ^ sign2, rneg = sign1.
- BYZERO: next edge → END with result_o = 0 and ready_o = 1.
- ON:
  - Each edge with cnt < DATA_W: shift {partial remainder, dividend} left 1 and trial-subtract the divisor magnitude (DATA_W+1-bit compare).
    - If non-negative: keep the difference and set the quotient bit to 1; otherwise the quotient bit is 0. MSB first.
    - cnt++.
  - Edge with cnt == DATA_W: apply sign fixup.
    - Quotient is negated if qneg. Remainder is negated if rneg. Unsigned: no fixup.
    - Load result_o, ready_o = 1, → END.
  - annul_i = 1 at any ON edge → FREE, cnt = 0, ready_o = 0, result_o = 0. Annul has priority over iteration and over completion.
- Latency, counting the start-sampling edge as edge 1:
  - Iterations occur on edges 2–33.
  - ready_o is high after edge 34.
  - Divide-by-zero: ready_o is high after edge 2.
- END:
  - Hold result_o and ready_o while start_i = 1.
  - start_i = 0 → FREE with ready_o = 0 and result_o = 0 on that edge.
  - annul_i is ignored in END.
- Operand changes after the start edge have no effect.
- Overflow case 0x80000000 / 0xFFFFFFFF, signed: quotient = 0x80000000, remainder = 0. No trap.
- ready_o is a single-source registered flag; it never glitches combinationally.

Test Plan:
- Unsigned 100/7: start with DIVU, hold start.
  - Required: ready_o = 0 through edge 33 and rises after edge 34.
  - Required: result_o = {32'd2, 32'd14}.
  - Drop start → ready_o = 0 and state FREE next edge.
- Signed −7/2 (0xFFFFFFF9 / 0x00000002, DIV): result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Also 7/−2 → {0x00000001, 0xFFFFFFFD}.
- Divide by zero (0x12345678 / 0, both signed and unsigned): ready_o high after edge 2, result_o = 0.
- Annul at edge 10 of an ON run:
  - Required: FREE next edge; ready_o never asserts.
  - A new start (0xFFFFFFFF / 1 unsigned) on the following cycle completes with {0, 0xFFFFFFFF} after 34 edges.
- Reset mid-run: rst = 0 at edge 20.
  - Required: ready_o = 0, result_o = 0, state FREE.
  - start_i held high through the reset release begins a fresh division on the first edge with rst = 1.
- Boundaries:
  - 0x80000000 / 0xFFFFFFFF signed → {0, 0x80000000}.
  - Same operands unsigned → {0x80000000, 0}.
  - start_i = 1 together with annul_i = 1 in FREE → no state change.
